mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Load/store port arbiter: one outstanding memory request, per-port completion, WAIT timeout.
// Latency: accept->mem_req_valid 1 cycle, resp_valid 1 cycle after mem_resp_valid. Define MEM_ARB_RR_EN for round-robin (default load-priority).
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wdata,
    input  logic [3:0]  st_wstrb,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,
    output logic        ld_resp_valid,
    output logic [31:0] ld_resp_rdata,
    output logic        ld_resp_err,
    output logic        st_resp_valid,
    output logic        st_resp_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    logic [1:0]  state;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_cnt_nxt;
    logic        timeout_hit;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        we_q;
    logic        owner_st_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        prefer_ld;
    logic        grant_ld;
    logic        ld_acc;
    logic        st_acc;

`ifdef MEM_ARB_RR_EN
    logic        last_grant_st;
    assign prefer_ld = last_grant_st;
`else
    assign prefer_ld = 1'b1;
`endif

    always_comb begin
        grant_ld = ld_valid && (!st_valid || prefer_ld);
        ld_ready = (state == S_IDLE) && grant_ld;
        st_ready = (state == S_IDLE) && st_valid && !grant_ld;
        ld_acc   = ld_valid && ld_ready;
        st_acc   = st_valid && st_ready;
    end

    // Counter value after this WAIT cycle; reaching the limit means the budget is spent.
    assign wait_cnt_nxt = wait_cnt + 8'd1;
    assign timeout_hit  = (wait_cnt_nxt == TIMEOUT_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wait_cnt   <= 8'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            we_q       <= 1'b0;
            owner_st_q <= 1'b0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_grant_st <= 1'b1;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (ld_acc || st_acc) begin
                        addr_q     <= ld_acc ? ld_addr : st_addr;
                        wdata_q    <= ld_acc ? 32'd0 : st_wdata;
                        wstrb_q    <= ld_acc ? 4'd0 : st_wstrb;
                        we_q       <= !ld_acc;
                        owner_st_q <= !ld_acc;
                        state      <= S_ISSUE;
`ifdef MEM_ARB_RR_EN
                        last_grant_st <= !ld_acc;
`endif
                    end
                end
                S_ISSUE: begin
                    if (mem_req_ready) begin
                        wait_cnt <= 8'd0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A response landing on the timeout cycle still wins.
                    if (mem_resp_valid) begin
                        rdata_q <= mem_rdata;
                        err_q   <= 1'b0;
                        state   <= S_RESP;
                    end else if (timeout_hit) begin
                        rdata_q <= 32'd0;
                        err_q   <= 1'b1;
                        state   <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt_nxt;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mem_req_valid = (state == S_ISSUE);
        mem_addr      = addr_q;
        mem_we        = we_q;
        mem_wdata     = wdata_q;
        mem_wstrb     = wstrb_q;
        ld_resp_valid = (state == S_RESP) && !owner_st_q;
        st_resp_valid = (state == S_RESP) && owner_st_q;
        ld_resp_rdata = ld_resp_valid ? rdata_q : 32'd0;
        ld_resp_err   = ld_resp_valid && err_q;
        st_resp_err   = st_resp_valid && err_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed transactions, queued expectations, negedge monitor.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct packed {
        logic        st;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [31:0] ld_addr = 32'd0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_addr = 32'd0;
    logic [31:0] st_wdata = 32'd0;
    logic [3:0]  st_wstrb = 4'd0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        ld_resp_valid;
    logic [31:0] ld_resp_rdata;
    logic        ld_resp_err;
    logic        st_resp_valid;
    logic        st_resp_err;

    int checks = 0;
    int failures = 0;
    req_t  exp_req[$];
    resp_t exp_resp[$];

    mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_wdata(st_wdata), .st_wstrb(st_wstrb),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .ld_resp_valid(ld_resp_valid), .ld_resp_rdata(ld_resp_rdata), .ld_resp_err(ld_resp_err),
        .st_resp_valid(st_resp_valid), .st_resp_err(st_resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ld(input logic [31:0] a, input logic [31:0] rd, input logic err);
        exp_req.push_back('{addr: a, we: 1'b0, wdata: 32'd0, wstrb: 4'd0});
        exp_resp.push_back('{st: 1'b0, rdata: rd, err: err});
    endtask

    task automatic push_st(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        exp_req.push_back('{addr: a, we: 1'b1, wdata: wd, wstrb: ws});
        exp_resp.push_back('{st: 1'b1, rdata: 32'd0, err: 1'b0});
    endtask

    // Wait (bounded) for a request, accept it, respond next cycle, finish in IDLE.
    task automatic serve_one(input logic [31:0] rd, input bit clear_valids);
        int n = 0;
        while (!mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n == 20) begin
            failures++;
            $display("FAIL serve_wait no mem_req_valid within 20 cycles t=%0t", $time);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        if (clear_valids) begin
            ld_valid = 1'b0;
            st_valid = 1'b0;
        end
        mem_resp_valid = 1'b1;
        mem_rdata = rd;
        tick();
        mem_resp_valid = 1'b0;
        tick();
    endtask

    // Monitor: compares every request handshake and every response pulse against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req_valid && mem_req_ready) begin
                if (exp_req.size() == 0) begin
                    chk("req_unexpected", 32'd1, 32'd0);
                end else begin
                    req_t e;
                    e = exp_req.pop_front();
                    chk("req_addr", mem_addr, e.addr);
                    chk("req_we", {31'd0, mem_we}, {31'd0, e.we});
                    chk("req_wdata", mem_wdata, e.wdata);
                    chk("req_wstrb", {28'd0, mem_wstrb}, {28'd0, e.wstrb});
                end
            end
            if (ld_resp_valid || st_resp_valid) begin
                chk("resp_both_ports", {31'd0, ld_resp_valid && st_resp_valid}, 32'd0);
                if (exp_resp.size() == 0) begin
                    chk("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    resp_t r;
                    r = exp_resp.pop_front();
                    chk("resp_port_st", {31'd0, st_resp_valid}, {31'd0, r.st});
                    if (r.st) begin
                        chk("st_resp_err", {31'd0, st_resp_err}, {31'd0, r.err});
                    end else begin
                        chk("ld_resp_rdata", ld_resp_rdata, r.rdata);
                        chk("ld_resp_err", {31'd0, ld_resp_err}, {31'd0, r.err});
                    end
                end
            end
        end
    end

    initial begin
        // Reset state
        tick();
        tick();
        @(negedge clk);
        chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_ld_resp_valid", {31'd0, ld_resp_valid}, 32'd0);
        chk("rst_st_resp_valid", {31'd0, st_resp_valid}, 32'd0);
        chk("rst_ld_ready_idle", {31'd0, ld_ready}, 32'd0);
        tick();
        rst = 1'b0;

        // Single store requester is granted combinationally, withdrawn before the edge
        st_valid = 1'b1;
        @(negedge clk);
        chk("single_st_ready", {31'd0, st_ready}, 32'd1);
        chk("single_ld_ready", {31'd0, ld_ready}, 32'd0);
        #1 st_valid = 1'b0;
        tick();

        // Minimum-latency load: accept T, issue T+1, resp T+2, ld_resp T+3, accept T+4
        ld_valid = 1'b1;
        ld_addr  = 32'h100;
        push_ld(32'h100, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        chk("ld_ready_T", {31'd0, ld_ready}, 32'd1);
        tick();
        ld_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk("mem_req_valid_T1", {31'd0, mem_req_valid}, 32'd1);
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("ld_resp_valid_T2", {31'd0, ld_resp_valid}, 32'd0);
        tick();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("ld_resp_valid_T3", {31'd0, ld_resp_valid}, 32'd1);
        tick();

        // Store with stalled mem_req_ready; a stray response during ISSUE is ignored
        st_valid = 1'b1;
        st_addr  = 32'h200;
        st_wdata = 32'h000000AA;
        st_wstrb = 4'b0001;
        push_st(32'h200, 32'h000000AA, 4'b0001);
        @(negedge clk);
        chk("st_ready_T4", {31'd0, st_ready}, 32'd1);
        chk("ld_resp_valid_T4", {31'd0, ld_resp_valid}, 32'd0);
        tick();
        st_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mem_req_ready  = (i == 5);
            mem_resp_valid = (i == 0);
            @(negedge clk);
            chk("st_hold_valid", {31'd0, mem_req_valid}, 32'd1);
            chk("st_hold_addr", mem_addr, 32'h200);
            chk("st_hold_we", {31'd0, mem_we}, 32'd1);
            chk("st_hold_wdata", mem_wdata, 32'h000000AA);
            chk("st_hold_wstrb", {28'd0, mem_wstrb}, 32'd1);
            tick();
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h12345678;
        tick();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("st_resp_valid", {31'd0, st_resp_valid}, 32'd1);
        tick();

        // Arbitration with both requesters held for four transactions after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = 32'h300;
        st_valid = 1'b1;
        st_addr  = 32'h400;
        st_wdata = 32'h55;
        st_wstrb = 4'hF;
        for (int k = 0; k < 4; k++) begin
            if (RR && (k % 2 == 1)) push_st(32'h400, 32'h55, 4'hF);
            else                    push_ld(32'h300, 32'hA0 + 32'(k), 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            serve_one(32'hA0 + 32'(k), k == 3);
        end
        ld_valid = 1'b0;
        st_valid = 1'b0;
        tick();

        // Timeout: no response for 4 WAIT cycles -> error, rdata 0
        ld_valid = 1'b1;
        ld_addr  = 32'h500;
        push_ld(32'h500, 32'd0, 1'b1);
        tick();
        ld_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("to_wait_no_resp", {31'd0, ld_resp_valid}, 32'd0);
            tick();
        end
        @(negedge clk);
        chk("to_resp_valid", {31'd0, ld_resp_valid}, 32'd1);
        chk("to_resp_err", {31'd0, ld_resp_err}, 32'd1);
        tick();
        @(negedge clk);
        chk("to_back_idle", {31'd0, ld_resp_valid}, 32'd0);

        // Response on the timeout cycle wins over the timeout
        #1;
        ld_valid = 1'b1;
        ld_addr  = 32'h510;
        push_ld(32'h510, 32'h0BADCAFE, 1'b0);
        tick();
        ld_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = (i == 3);
            mem_rdata = 32'h0BADCAFE;
            tick();
        end
        mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("tie_resp_valid", {31'd0, ld_resp_valid}, 32'd1);
        tick();

        // Reset during WAIT drops the request; a late response is ignored
        ld_valid = 1'b1;
        ld_addr  = 32'h600;
        exp_req.push_back('{addr: 32'h600, we: 1'b0, wdata: 32'd0, wstrb: 4'd0});
        tick();
        ld_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_wait_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_wait_addr", mem_addr, 32'd0);
        #1;
        rst = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        tick();
        mem_resp_valid = 1'b0;
        tick();
        ld_valid = 1'b1;
        ld_addr  = 32'h700;
        push_ld(32'h700, 32'hCAFEF00D, 1'b0);
        serve_one(32'hCAFEF00D, 1'b1);
        tick();
        tick();

        chk("req_queue_drained", 32'(exp_req.size()), 32'd0);
        chk("resp_queue_drained", 32'(exp_resp.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
